// File: rtl/d1_inst_aligner.sv
// Aligns RV32IC instructions from IBuff fetch lines into NUM_OUT decode slots, stitching line-crossing instructions.
// Latency: a line accepted in cycle N drives its slots in cycle N+1. Slots are taken all-or-nothing on out_ready.
`timescale 1ns/1ps
module d1_inst_aligner #(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = 64,
  parameter int REGIONS    = 4,
  parameter int NUM_OUT    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_resteer,
  input  logic                    i_line_valid,
  output logic                    o_line_ready,
  input  logic [XLEN-1:0]         i_line_pc,
  input  logic [LINE_BYTES*8-1:0] i_line_data,
  input  logic [REGIONS-1:0]      i_line_region_valid,
  input  logic                    i_line_exc,
  output logic [NUM_OUT-1:0]      o_out_valid,
  output logic [NUM_OUT*32-1:0]   o_out_inst,
  output logic [NUM_OUT*XLEN-1:0] o_out_pc,
  output logic [NUM_OUT-1:0]      o_out_compressed,
  output logic                    o_out_exc,
  input  logic                    i_out_ready
);

  localparam int OFFW = $clog2(LINE_BYTES);
  localparam int PW   = OFFW + 3;
  localparam int RSH  = $clog2(LINE_BYTES / REGIONS);
  localparam int RW   = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam logic [PW-1:0] LB = PW'(LINE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_STITCH, S_HALT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LINE_BYTES*8-1:0] r_line, w_line_nxt;
  logic [REGIONS-1:0]      r_rv, w_rv_nxt;
  logic [XLEN-1:0]         r_base, w_base_nxt;
  logic [OFFW:0]           r_offset, w_offset_nxt;
  logic                    r_stitch, w_stitch_nxt;
  logic [15:0]             r_stitch_lo, w_stitch_lo_nxt;
  logic [XLEN-1:0]         r_stitch_pc, w_stitch_pc_nxt;
  logic                    r_exc, w_exc_nxt;
  logic [XLEN-1:0]         r_exc_pc, w_exc_pc_nxt;

  logic            w_accept, w_fire, w_n32, w_nhw_ok, w_next_ok, w_stitch_hit;
  logic [PW-1:0]   w_consumed, w_new_off;
  logic [15:0]     w_nhw;
  logic [XLEN-1:0] w_in_base;
  logic [OFFW:0]   w_in_off;

  function automatic logic [15:0] hw_at(input logic [LINE_BYTES*8-1:0] line, input logic [PW-1:0] pos);
    return 16'(line >> {pos, 3'b000});
  endfunction

  // Both end bytes must sit in valid regions and inside the line.
  function automatic logic regions_ok(input logic [REGIONS-1:0] rv, input logic [PW-1:0] first,
                                      input logic [PW-1:0] last);
    logic [PW-1:0] f_idx, l_idx;
    f_idx = first >> RSH;
    l_idx = last >> RSH;
    return (last < LB) && rv[RW'(f_idx)] && rv[RW'(l_idx)];
  endfunction

  assign o_line_ready = (r_state != S_ALIGN) && !i_resteer;
  assign w_accept     = i_line_valid && o_line_ready;
  assign w_fire       = i_out_ready && o_out_valid[0];
  assign o_out_exc    = o_out_valid[0] && r_exc;

  assign w_new_off = w_fire ? PW'(r_offset) + w_consumed : PW'(r_offset);
  assign w_nhw     = hw_at(r_line, w_new_off);
  assign w_n32     = (w_nhw[1:0] == 2'b11);
  assign w_nhw_ok  = regions_ok(r_rv, w_new_off, w_new_off + PW'(1));
  assign w_next_ok = w_nhw_ok && (!w_n32 || regions_ok(r_rv, w_new_off, w_new_off + PW'(3)));

  assign w_in_base    = {i_line_pc[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_in_off     = {1'b0, i_line_pc[OFFW-1:0] & ~(OFFW'(1))};
  assign w_stitch_hit = (w_in_base == r_stitch_pc + XLEN'(2)) && i_line_region_valid[0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_line_nxt      = r_line;
    w_rv_nxt        = r_rv;
    w_base_nxt      = r_base;
    w_offset_nxt    = r_offset;
    w_stitch_nxt    = r_stitch;
    w_stitch_lo_nxt = r_stitch_lo;
    w_stitch_pc_nxt = r_stitch_pc;
    w_exc_nxt       = r_exc;
    w_exc_pc_nxt    = r_exc_pc;
    if (i_resteer) begin
      w_state_nxt  = S_IDLE;
      w_stitch_nxt = 1'b0;
      w_exc_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_STITCH: begin
          if (w_accept) begin
            w_state_nxt  = S_ALIGN;
            w_stitch_nxt = 1'b0;
            if (i_line_exc) begin
              w_exc_nxt    = 1'b1;
              w_exc_pc_nxt = (r_state == S_STITCH) ? r_stitch_pc : i_line_pc;
            end else begin
              w_line_nxt   = i_line_data;
              w_rv_nxt     = i_line_region_valid;
              w_base_nxt   = w_in_base;
              w_offset_nxt = w_in_off;
              // The held low half becomes slot 0; the line's first halfword is consumed by it.
              if (r_state == S_STITCH && w_stitch_hit) begin
                w_offset_nxt = '0;
                w_stitch_nxt = 1'b1;
              end
            end
          end
        end
        S_ALIGN: begin
          if (r_exc) begin
            if (w_fire) begin
              w_state_nxt = S_HALT;
              w_exc_nxt   = 1'b0;
            end
          end else if (w_fire || !o_out_valid[0]) begin
            w_stitch_nxt = 1'b0;
            w_offset_nxt = (OFFW+1)'(w_new_off);
            if (w_new_off >= LB) begin
              w_state_nxt = S_IDLE;
            end else if (w_new_off == LB - PW'(2) && w_nhw_ok && w_n32) begin
              w_state_nxt     = S_STITCH;
              w_stitch_lo_nxt = w_nhw;
              w_stitch_pc_nxt = r_base + XLEN'(LINE_BYTES - 2);
            end else if (!w_next_ok) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin : slot_comb
    logic [PW-1:0] w_pos, w_len;
    logic [15:0]   w_hw;
    logic [31:0]   w_wd;
    logic          w_run, w_ok;
    w_pos            = PW'(r_offset);
    w_run            = (r_state == S_ALIGN) && !i_resteer;
    w_consumed       = '0;
    o_out_valid      = '0;
    o_out_inst       = '0;
    o_out_pc         = '0;
    o_out_compressed = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_hw  = hw_at(r_line, w_pos);
      w_wd  = 32'(r_line >> {w_pos, 3'b000});
      w_len = (w_hw[1:0] == 2'b11) ? PW'(4) : PW'(2);
      w_ok  = regions_ok(r_rv, w_pos, w_pos + w_len - PW'(1));
      o_out_compressed[k]      = (w_hw[1:0] != 2'b11);
      o_out_inst[32*k +: 32]   = (w_hw[1:0] == 2'b11) ? w_wd : {16'h0000, w_hw};
      o_out_pc[XLEN*k +: XLEN] = r_base + XLEN'(w_pos);
      if (k == 0 && r_stitch) begin
        w_len                    = PW'(2);
        w_ok                     = 1'b1;
        o_out_compressed[k]      = 1'b0;
        o_out_inst[32*k +: 32]   = {w_hw, r_stitch_lo};
        o_out_pc[XLEN*k +: XLEN] = r_stitch_pc;
      end
      if (r_exc) begin
        w_ok                     = (k == 0);
        o_out_compressed[k]      = 1'b0;
        o_out_inst[32*k +: 32]   = '0;
        o_out_pc[XLEN*k +: XLEN] = r_exc_pc;
      end
      w_run          = w_run && w_ok;
      o_out_valid[k] = w_run;
      if (w_run) w_consumed = w_consumed + w_len;
      w_pos = w_pos + w_len;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_line      <= '0;
      r_rv        <= '0;
      r_base      <= '0;
      r_offset    <= '0;
      r_stitch    <= 1'b0;
      r_stitch_lo <= '0;
      r_stitch_pc <= '0;
      r_exc       <= 1'b0;
      r_exc_pc    <= '0;
    end else begin
      r_line      <= w_line_nxt;
      r_rv        <= w_rv_nxt;
      r_base      <= w_base_nxt;
      r_offset    <= w_offset_nxt;
      r_stitch    <= w_stitch_nxt;
      r_stitch_lo <= w_stitch_lo_nxt;
      r_stitch_pc <= w_stitch_pc_nxt;
      r_exc       <= w_exc_nxt;
      r_exc_pc    <= w_exc_pc_nxt;
    end
  end

endmodule

// File: tb/tb_d1_inst_aligner.sv
// Scoreboard bench for d1_inst_aligner: directed lines, expected slots queued, negedge monitor pops on fire.
`timescale 1ns/1ps
module tb_d1_inst_aligner;
  logic         clk = 1'b0, rst_n = 1'b0, resteer = 1'b0;
  logic         line_valid = 1'b0, line_exc = 1'b0, out_ready = 1'b1;
  logic [31:0]  line_pc = '0;
  logic [511:0] line_data = '0;
  logic [3:0]   line_rv = '0;
  logic         line_ready, out_exc;
  logic [1:0]   out_valid, out_comp;
  logic [63:0]  out_inst, out_pc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        comp;
    logic        exc;
  } exp_t;
  exp_t sb[$];
  exp_t act_s, exp_s;

  always #5 clk = ~clk;

  d1_inst_aligner dut (
    .i_clk(clk), .i_rst(rst_n), .i_resteer(resteer),
    .i_line_valid(line_valid), .o_line_ready(line_ready), .i_line_pc(line_pc),
    .i_line_data(line_data), .i_line_region_valid(line_rv), .i_line_exc(line_exc),
    .o_out_valid(out_valid), .o_out_inst(out_inst), .o_out_pc(out_pc),
    .o_out_compressed(out_comp), .o_out_exc(out_exc), .i_out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int slot, input logic [31:0] pc, input logic [31:0] inst,
                      input logic comp, input logic exc);
    exp_t e;
    e.slot = 2'(slot); e.pc = pc; e.inst = inst; e.comp = comp; e.exc = exc;
    sb.push_back(e);
  endtask

  task automatic send_line(input logic [31:0] pc, input logic [511:0] d, input logic [3:0] rv,
                           input logic exc);
    logic got = 1'b0;
    @(posedge clk); #1;
    line_pc = pc; line_data = d; line_rv = rv; line_exc = exc; line_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = line_ready;
    end
    check("line_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    line_valid = 1'b0; line_exc = 1'b0;
  endtask

  task automatic drain(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && line_ready;
    end
    check(name, {63'(sb.size()), line_ready}, 64'd1);
  endtask

  // Monitor: every valid slot of a fired bundle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_ready && out_valid[0]) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          act_s.slot = 2'(k);
          act_s.pc   = out_pc[32*k +: 32];
          act_s.inst = out_inst[32*k +: 32];
          act_s.comp = out_comp[k];
          act_s.exc  = (k == 0) ? out_exc : 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL slot_unexpected: got slot=%0d pc=%h inst=%h, none expected",
                     act_s.slot, act_s.pc, act_s.inst);
          end else begin
            exp_s = sb.pop_front();
            if (act_s !== exp_s) begin
              errors++;
              $display("FAIL slot_compare: got slot=%0d pc=%h inst=%h comp=%b exc=%b expected slot=%0d pc=%h inst=%h comp=%b exc=%b",
                       act_s.slot, act_s.pc, act_s.inst, act_s.comp, act_s.exc,
                       exp_s.slot, exp_s.pc, exp_s.inst, exp_s.comp, exp_s.exc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d expected completion", checks);
    $fatal(1);
  end

  initial begin
    logic [511:0] d, d32;
    // Reset
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_exc", 64'(out_exc), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_line_ready", 64'(line_ready), 64'd1);

    // 1: sixteen 32-bit instructions, two per cycle
    d32 = '0;
    for (int i = 0; i < 16; i++) begin
      d32[32*i +: 32] = 32'h5000_0003 | (i << 8);
      push(i % 2, 32'h1000 + 4 * i, 32'h5000_0003 | (i << 8), 1'b0, 1'b0);
    end
    send_line(32'h1000, d32, 4'b1111, 1'b0);
    drain("t1_drain");

    // 2: mixed RVC, only region 0 usable
    d = '0;
    d[0 +: 16] = 16'h4501; d[16 +: 32] = 32'h00C5_8593; d[48 +: 16] = 16'h0505;
    d[64 +: 16] = 16'h0001; d[80 +: 16] = 16'h0002; d[96 +: 32] = 32'h0040_0013;
    push(0, 32'h2000, 32'h0000_4501, 1'b1, 1'b0);
    push(1, 32'h2002, 32'h00C5_8593, 1'b0, 1'b0);
    push(0, 32'h2006, 32'h0000_0505, 1'b1, 1'b0);
    push(1, 32'h2008, 32'h0000_0001, 1'b1, 1'b0);
    push(0, 32'h200A, 32'h0000_0002, 1'b1, 1'b0);
    push(1, 32'h200C, 32'h0040_0013, 1'b0, 1'b0);
    send_line(32'h2000, d, 4'b0001, 1'b0);
    drain("t2_drain");

    // 3: 32-bit instruction crossing from 0x303E into the next line
    d = '0;
    d[448 +: 32] = 32'hAAAA_BBB3; d[480 +: 16] = 16'h1111; d[496 +: 16] = 16'hCDE7;
    push(0, 32'h3038, 32'hAAAA_BBB3, 1'b0, 1'b0);
    push(1, 32'h303C, 32'h0000_1111, 1'b1, 1'b0);
    send_line(32'h3038, d, 4'b1111, 1'b0);
    d = '0;
    d[0 +: 16] = 16'h9876; d[16 +: 16] = 16'h0009; d[32 +: 32] = 32'h0000_0073;
    d[64 +: 16] = 16'h0011; d[80 +: 16] = 16'h0015; d[96 +: 16] = 16'h0019; d[112 +: 16] = 16'h001D;
    push(0, 32'h303E, 32'h9876_CDE7, 1'b0, 1'b0);
    push(1, 32'h3042, 32'h0000_0009, 1'b1, 1'b0);
    push(0, 32'h3044, 32'h0000_0073, 1'b0, 1'b0);
    push(1, 32'h3048, 32'h0000_0011, 1'b1, 1'b0);
    push(0, 32'h304A, 32'h0000_0015, 1'b1, 1'b0);
    push(1, 32'h304C, 32'h0000_0019, 1'b1, 1'b0);
    push(0, 32'h304E, 32'h0000_001D, 1'b1, 1'b0);
    send_line(32'h3040, d, 4'b0001, 1'b0);
    drain("t3_drain");

    // 4: start in invalid upper half -> nothing emitted, line released
    send_line(32'h4020, d32, 4'b0011, 1'b0);
    @(negedge clk);
    check("t4_no_slot", 64'(out_valid), 64'd0);
    check("t4_held_ready", 64'(line_ready), 64'd0);
    @(negedge clk);
    check("t4_released_ready", 64'(line_ready), 64'd1);

    // Resteer while slots are valid: suppressed, no fire, back to IDLE
    out_ready = 1'b0;
    send_line(32'h8000, d32, 4'b1111, 1'b0);
    @(negedge clk);
    check("rs_align_valid", 64'(out_valid), 64'd3);
    #1 resteer = 1'b1; out_ready = 1'b1;
    #1;
    check("rs_align_valid_masked", 64'(out_valid), 64'd0);
    check("rs_align_ready_masked", 64'(line_ready), 64'd0);
    @(posedge clk); #1 resteer = 1'b0;
    @(negedge clk);
    check("rs_align_after_valid", 64'(out_valid), 64'd0);
    check("rs_align_after_ready", 64'(line_ready), 64'd1);

    // 5: fetch exception, halt, resteer, then normal decode
    push(0, 32'h5000, 32'h0, 1'b0, 1'b1);
    send_line(32'h5000, d32, 4'b1111, 1'b1);
    drain("t5_exc_drain");
    check("t5_halt_ready", 64'(line_ready), 64'd1);
    send_line(32'h5040, d32, 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_halt_silent", 64'(out_valid), 64'd0);
    @(posedge clk); #1 resteer = 1'b1;
    @(negedge clk);
    check("t5_resteer_ready", 64'(line_ready), 64'd0);
    @(posedge clk); #1 resteer = 1'b0;
    d = '0;
    d[0 +: 32] = 32'h0123_4567; d[32 +: 16] = 16'h0002; d[48 +: 16] = 16'h0006;
    d[64 +: 32] = 32'h89AB_CDEF; d[96 +: 32] = 32'h0000_0013;
    push(0, 32'h6000, 32'h0123_4567, 1'b0, 1'b0);
    push(1, 32'h6004, 32'h0000_0002, 1'b1, 1'b0);
    push(0, 32'h6006, 32'h0000_0006, 1'b1, 1'b0);
    push(1, 32'h6008, 32'h89AB_CDEF, 1'b0, 1'b0);
    push(0, 32'h600C, 32'h0000_0013, 1'b0, 1'b0);
    send_line(32'h6000, d, 4'b0001, 1'b0);
    drain("t5_6000_drain");

    // 6: resteer in STITCH, next line 0x7010 decodes from offset 0x10
    d = '0;
    d[496 +: 16] = 16'h0003;
    send_line(32'h703E, d, 4'b1111, 1'b0);
    begin
      logic st = 1'b0;
      for (int i = 0; i < 20 && !st; i++) begin
        @(negedge clk);
        st = line_ready;
      end
      check("t6_stitch_ready", 64'(st), 64'd1);
    end
    #1 resteer = 1'b1;
    #1;
    check("t6_resteer_valid", 64'(out_valid), 64'd0);
    check("t6_resteer_ready", 64'(line_ready), 64'd0);
    @(posedge clk); #1 resteer = 1'b0;
    d = '0;
    d[128 +: 16] = 16'h0041; d[144 +: 32] = 32'h0000_0093; d[176 +: 16] = 16'h0045;
    d[192 +: 32] = 32'h0000_00B3; d[224 +: 16] = 16'h0049; d[240 +: 16] = 16'h004D;
    push(0, 32'h7010, 32'h0000_0041, 1'b1, 1'b0);
    push(1, 32'h7012, 32'h0000_0093, 1'b0, 1'b0);
    push(0, 32'h7016, 32'h0000_0045, 1'b1, 1'b0);
    push(1, 32'h7018, 32'h0000_00B3, 1'b0, 1'b0);
    push(0, 32'h701C, 32'h0000_0049, 1'b1, 1'b0);
    push(1, 32'h701E, 32'h0000_004D, 1'b1, 1'b0);
    send_line(32'h7010, d, 4'b0010, 1'b0);
    drain("t6_drain");

    repeat (3) @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
